// File: rtl/conf_pkg.sv
// conf_pkg: shared register map for conf_regs.
// Contains the register offsets, COR/CCSR bit positions, the CCSR writable
// mask, register reset values and the CCSR write-merge helper.
package conf_pkg;

  // Register offsets (register i sits at A[8:0] = 2*i)
  localparam int COR_IDX  = 0;
  localparam int CCSR_IDX = 1;

  // COR bit positions
  localparam int COR_INDEX_MSB = 5;
  localparam int COR_LEVLREQ   = 6;
  localparam int COR_SRESET    = 7;

  // CCSR bit positions
  localparam int CCSR_INTR   = 1;
  localparam int CCSR_PWRDWN = 2;
  localparam int CCSR_AUDIO  = 3;
  localparam int CCSR_IOIS8  = 5;

  // Plain read/write CCSR bits; Intr is write-1-to-clear, the rest read 0
  localparam logic [7:0] CCSR_WMASK =
    8'((1 << CCSR_PWRDWN) | (1 << CCSR_AUDIO) | (1 << CCSR_IOIS8));
  localparam logic [7:0] CCSR_INTR_MASK = 8'(1 << CCSR_INTR);

  // COR value held while the card core is in soft reset
  localparam logic [7:0] COR_SRESET_ONLY = 8'(1 << COR_SRESET);

  // Reset value of every register
  localparam logic [7:0] REG_RST = 8'h00;

  // Host write into CCSR: plain bits take the data, Intr clears on a 1
  function automatic logic [7:0] ccsr_write(input logic [7:0] cur,
                                            input logic [7:0] wdata);
    return (wdata & CCSR_WMASK) | (cur & CCSR_INTR_MASK & ~wdata);
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: 2-flop synchroniser with registered edge flags.
// rise_o/fall_o are high for one CLK on the same cycle sync_o changes.
// RST_VAL sets the reset level so idle-high strobes give no edge at reset exit.
module strobe_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic strobe_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic rise_q;
  logic fall_q;

  // Two-stage synchroniser; edges computed from the stage feeding sync_q
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= strobe_i;
      sync_q <= meta_q;
      rise_q <= meta_q & ~sync_q;
      fall_q <= ~meta_q & sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/conf_regs.sv
// conf_regs: attribute-memory configuration registers (COR, CCSR, scratch)
// with interrupt request generation and optional COR soft-reset sequencing.
// Build option: define CONF_SRESET_EN to enable COR.SRESET soft reset and
// the RST_HOLD release window; otherwise COR[7] is plain storage.
// Handshake: the host has no valid/ready; a write is a WE low period with
// REGSELB low, and it commits on the synchronised WE rising edge.
module conf_regs
  import conf_pkg::*;
#(
  parameter int         NUM_REGS     = 4,
  parameter logic [5:0] CONFIG_INDEX = 6'd1,
  parameter int         PULSE_CYCLES = 8,
  parameter int         RST_HOLD     = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  D_in,
  input  logic [15:0] A,
  input  logic        REGSELB,
  input  logic        OE,
  input  logic        WE,
  input  logic        IRQ_IN,
  output logic [7:0]  D_out,
  output logic        DDIR,
  output logic        CONFIGURED,
  output logic        IREQ,
  output logic        SOFT_RESET
);

  logic we_sync, we_rise, we_fall;
  logic rsel_sync, rsel_rise, rsel_fall;
  logic irq_sync, irq_rise, irq_fall;

  strobe_sync #(.RST_VAL(1'b1)) u_we_sync (
    .CLK(CLK), .RESET(RESET), .strobe_i(WE),
    .sync_o(we_sync), .rise_o(we_rise), .fall_o(we_fall));

  strobe_sync #(.RST_VAL(1'b1)) u_rsel_sync (
    .CLK(CLK), .RESET(RESET), .strobe_i(REGSELB),
    .sync_o(rsel_sync), .rise_o(rsel_rise), .fall_o(rsel_fall));

  strobe_sync #(.RST_VAL(1'b0)) u_irq_sync (
    .CLK(CLK), .RESET(RESET), .strobe_i(IRQ_IN),
    .sync_o(irq_sync), .rise_o(irq_rise), .fall_o(irq_fall));

  logic unused_sig;
  assign unused_sig = ^{A[15:10], we_fall, rsel_rise, rsel_fall, irq_sync, irq_fall};

  logic [9:0] cap_a_q, cap_a_d;
  logic [7:0] cap_d_q, cap_d_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] pulse_cnt_q, pulse_cnt_d;
  logic       ireq_q, ireq_d;
  logic       wr_en;
  logic [7:0] wr_idx;
  logic       locked;
  logic       levl_req;
  logic       intr_set;

  // Read side is purely combinational so reads see no clock latency
  assign DDIR       = ~REGSELB & ~OE & A[9];
  assign CONFIGURED = (regs_q[COR_IDX][COR_INDEX_MSB:0] == CONFIG_INDEX);
  assign levl_req   = regs_q[COR_IDX][COR_LEVLREQ];
  assign IREQ       = ireq_q;

  // Read mux: even addresses inside the register range, otherwise zero
  always_comb begin
    D_out = 8'h00;
    if (!A[0]) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (A[8:1] == 8'(i)) D_out = regs_q[i];
      end
    end
  end

  // Keep sampling address/data while the synced write strobe is active
  always_comb begin
    cap_a_d = cap_a_q;
    cap_d_d = cap_d_q;
    if (!we_sync && !rsel_sync) begin
      cap_a_d = A[9:0];
      cap_d_d = D_in;
    end
  end

  assign wr_en  = we_rise & cap_a_q[9] & ~cap_a_q[0];
  assign wr_idx = cap_a_q[8:1];

  // Register next state: host commit, then Intr set (set beats clear)
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && wr_idx == 8'(i)) begin
        if (i == COR_IDX) begin
          regs_d[i] = cap_d_q;
        end else if (!locked) begin
          if (i == CCSR_IDX) regs_d[i] = ccsr_write(regs_q[i], cap_d_q);
          else               regs_d[i] = cap_d_q;
        end
      end
    end
    if (irq_rise) regs_d[CCSR_IDX][CCSR_INTR] = 1'b1;
`ifdef CONF_SRESET_EN
    if (regs_d[COR_IDX][COR_SRESET]) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i != COR_IDX) regs_d[i] = REG_RST;
      end
      regs_d[COR_IDX] = COR_SRESET_ONLY;
    end
`endif
  end

  assign intr_set = regs_d[CCSR_IDX][CCSR_INTR] & ~regs_q[CCSR_IDX][CCSR_INTR];

  // Pulse counter: loads on an Intr 0->1 in pulse mode, never restarts mid-pulse
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (intr_set && CONFIGURED && !levl_req && pulse_cnt_q == 8'd0)
      pulse_cnt_d = 8'(PULSE_CYCLES);
    else if (pulse_cnt_q != 8'd0)
      pulse_cnt_d = pulse_cnt_q - 8'd1;
    ireq_d = CONFIGURED & (levl_req ? regs_q[CCSR_IDX][CCSR_INTR]
                                    : (pulse_cnt_q != 8'd0));
  end

  // Capture, register file, pulse counter and IREQ state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cap_a_q     <= 10'd0;
      cap_d_q     <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST;
      pulse_cnt_q <= 8'd0;
      ireq_q      <= 1'b0;
    end else begin
      cap_a_q     <= cap_a_d;
      cap_d_q     <= cap_d_d;
      regs_q      <= regs_d;
      pulse_cnt_q <= pulse_cnt_d;
      ireq_q      <= ireq_d;
    end
  end

`ifdef CONF_SRESET_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Non-COR writes are blocked in soft reset and during the release window
  assign locked     = regs_q[COR_IDX][COR_SRESET] | (hold_cnt_q != 8'd0);
  assign SOFT_RESET = regs_q[COR_IDX][COR_SRESET] | (hold_cnt_q != 8'd0);

  // Hold window starts when SRESET is cleared; re-setting SRESET cancels it
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (regs_d[COR_IDX][COR_SRESET])      hold_cnt_d = 8'd0;
    else if (regs_q[COR_IDX][COR_SRESET]) hold_cnt_d = 8'(RST_HOLD);
    else if (hold_cnt_q != 8'd0)          hold_cnt_d = hold_cnt_q - 8'd1;
  end

  // Hold counter state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) hold_cnt_q <= 8'd0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  logic [7:0] unused_hold;
  assign unused_hold = 8'(RST_HOLD);
  assign locked      = 1'b0;
  assign SOFT_RESET  = 1'b0;
`endif

endmodule

// File: tb/tb_conf_regs.sv
// tb_conf_regs: directed bench for conf_regs (default parameters).
// Soft-reset sequences are exercised when built with CONF_SRESET_EN.
module tb_conf_regs;

  logic        CLK;
  logic        RESET;
  logic [7:0]  D_in;
  logic [15:0] A;
  logic        REGSELB;
  logic        OE;
  logic        WE;
  logic        IRQ_IN;
  logic [7:0]  D_out;
  logic        DDIR;
  logic        CONFIGURED;
  logic        IREQ;
  logic        SOFT_RESET;

  int n_checks = 0;
  int n_fail   = 0;

  conf_regs dut (
    .CLK(CLK), .RESET(RESET), .D_in(D_in), .A(A), .REGSELB(REGSELB),
    .OE(OE), .WE(WE), .IRQ_IN(IRQ_IN), .D_out(D_out), .DDIR(DDIR),
    .CONFIGURED(CONFIGURED), .IREQ(IREQ), .SOFT_RESET(SOFT_RESET));

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        do_wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [7:0]  exp_rd;
    logic        exp_ddir;
    logic        exp_conf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // driver: full host write, returns on the negedge after the commit edge
  task automatic host_write(input logic [15:0] addr, input logic [7:0] data, input logic irq_too);
    @(negedge CLK);
    A = addr; D_in = data; REGSELB = 1'b0; WE = 1'b0; OE = 1'b1;
    repeat (4) @(negedge CLK);
    WE = 1'b1;
    if (irq_too) IRQ_IN = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    REGSELB = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] addr);
    @(negedge CLK);
    A = addr; REGSELB = 1'b0; OE = 1'b0;
    #1;
  endtask

  task automatic reset_checks(input string tag);
    A = 16'h0200; REGSELB = 1'b0; OE = 1'b0;
    #1;
    check({tag, "_cor"}, 16'(D_out), 16'h00);
    check({tag, "_conf"}, 16'(CONFIGURED), 16'h0);
    check({tag, "_ireq"}, 16'(IREQ), 16'h0);
    check({tag, "_sreset"}, 16'(SOFT_RESET), 16'h0);
    A = 16'h0202;
    #1;
    check({tag, "_ccsr"}, 16'(D_out), 16'h00);
    A = 16'h0204;
    #1;
    check({tag, "_scratch"}, 16'(D_out), 16'h00);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    int cnt;
    vecs[0]  = '{1'b1, 16'h0200, 8'h02, 16'h0200, 8'h02, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'h0201, 8'hAA, 16'h0201, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h0208, 8'hAA, 16'h0208, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 8'h00, 16'h0200, 8'h02, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 8'h00, 16'h0202, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 16'h0204, 8'h5A, 16'h0204, 8'h5A, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'h0206, 8'hC3, 16'h0206, 8'hC3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 16'h0202, 8'hFF, 16'h0202, 8'h2C, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h0202, 8'h00, 16'h0202, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0004, 8'h11, 16'h0204, 8'h5A, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 8'h00, 16'h0004, 8'h5A, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h0200, 8'h01, 16'h0200, 8'h01, 1'b1, 1'b1};

    RESET = 1'b1; D_in = 8'h00; A = 16'h0000; REGSELB = 1'b1; OE = 1'b1;
    WE = 1'b1; IRQ_IN = 1'b0;
    repeat (2) @(negedge CLK);
    reset_checks("por");
    REGSELB = 1'b1; OE = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // write latency: COR=0x01 appears exactly on the third edge after WE rise
    A = 16'h0200; D_in = 8'h01; REGSELB = 1'b0; WE = 1'b0;
    repeat (4) @(negedge CLK);
    WE = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("cor_before_commit", 16'(D_out), 16'h00);
    @(posedge CLK);
    #1;
    check("cor_at_commit", 16'(D_out), 16'h01);
    check("conf_at_commit", 16'(CONFIGURED), 16'h1);
    @(negedge CLK);
    REGSELB = 1'b1;
    check("ddir_off_regselb", 16'(DDIR), 16'h0);

    // table of write/read vectors
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].do_wr) host_write(vecs[v].wa, vecs[v].wd, 1'b0);
      do_read(vecs[v].ra);
      check($sformatf("vec%0d_rd", v), 16'(D_out), 16'(vecs[v].exp_rd));
      check($sformatf("vec%0d_ddir", v), 16'(DDIR), 16'(vecs[v].exp_ddir));
      check($sformatf("vec%0d_conf", v), 16'(CONFIGURED), 16'(vecs[v].exp_conf));
      check($sformatf("vec%0d_ireq", v), 16'(IREQ), 16'h0);
      OE = 1'b1; REGSELB = 1'b1;
    end

    // pulse mode: Intr set 3 cycles after IRQ_IN rise, IREQ high for 8 cycles
    @(negedge CLK);
    A = 16'h0202; REGSELB = 1'b0; OE = 1'b0; IRQ_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("intr_before_set", 16'(D_out), 16'h00);
    @(posedge CLK);
    #1;
    check("intr_set", 16'(D_out), 16'h02);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (IREQ) cnt++;
      if (k == 2) IRQ_IN = 1'b0;
    end
    check("pulse_len", 16'(cnt), 16'd8);
    OE = 1'b1; REGSELB = 1'b1;
    host_write(16'h0202, 8'h02, 1'b0);
    do_read(16'h0202);
    check("intr_w1c", 16'(D_out), 16'h00);

    // level mode
    host_write(16'h0200, 8'h41, 1'b0);
    do_read(16'h0200);
    check("cor_level", 16'(D_out), 16'h41);
    check("conf_level", 16'(CONFIGURED), 16'h1);
    A = 16'h0202;
    @(negedge CLK);
    IRQ_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("lvl_intr_set", 16'(D_out), 16'h02);
    check("lvl_ireq_lag", 16'(IREQ), 16'h0);
    @(posedge CLK);
    #1;
    check("lvl_ireq_on", 16'(IREQ), 16'h1);
    repeat (10) @(posedge CLK);
    #1;
    check("lvl_ireq_hold", 16'(IREQ), 16'h1);
    IRQ_IN = 1'b0;
    repeat (4) @(negedge CLK);
    // clear and fresh IRQ edge land on the same cycle: set wins
    host_write(16'h0202, 8'h02, 1'b1);
    do_read(16'h0202);
    check("set_beats_clear", 16'(D_out), 16'h02);
    check("set_beats_clear_ireq", 16'(IREQ), 16'h1);
    IRQ_IN = 1'b0; OE = 1'b1; REGSELB = 1'b1;
    repeat (4) @(negedge CLK);
    host_write(16'h0202, 8'h02, 1'b0);
    do_read(16'h0202);
    check("lvl_cleared", 16'(D_out), 16'h00);
    check("lvl_ireq_off", 16'(IREQ), 16'h0);
    OE = 1'b1; REGSELB = 1'b1;

`ifdef CONF_SRESET_EN
    host_write(16'h0200, 8'h80, 1'b0);
    check("sreset_on", 16'(SOFT_RESET), 16'h1);
    do_read(16'h0200);
    check("sreset_cor", 16'(D_out), 16'h80);
    check("sreset_conf", 16'(CONFIGURED), 16'h0);
    do_read(16'h0204);
    check("sreset_scratch_clr", 16'(D_out), 16'h00);
    host_write(16'h0204, 8'h77, 1'b0);
    do_read(16'h0204);
    check("sreset_scratch_wr", 16'(D_out), 16'h00);
    host_write(16'h0200, 8'h00, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (SOFT_RESET) cnt++;
      @(negedge CLK);
    end
    check("hold_len", 16'(cnt), 16'd16);
    // hold window: scratch write ignored
    host_write(16'h0200, 8'h80, 1'b0);
    host_write(16'h0200, 8'h00, 1'b0);
    host_write(16'h0206, 8'h55, 1'b0);
    do_read(16'h0206);
    check("hold_scratch_wr", 16'(D_out), 16'h00);
    check("hold_sreset", 16'(SOFT_RESET), 16'h1);
    // re-entry during hold
    host_write(16'h0200, 8'h00, 1'b0);
    host_write(16'h0200, 8'h80, 1'b0);
    repeat (30) @(negedge CLK);
    check("reenter_sreset", 16'(SOFT_RESET), 16'h1);
    do_read(16'h0200);
    check("reenter_cor", 16'(D_out), 16'h80);
    OE = 1'b1; REGSELB = 1'b1;
    // reset mid-hold
    host_write(16'h0200, 8'h00, 1'b0);
    repeat (3) @(negedge CLK);
    check("midhold_sreset", 16'(SOFT_RESET), 16'h1);
    #2 RESET = 1'b1;
    reset_checks("midhold");
    @(negedge CLK);
    RESET = 1'b0; OE = 1'b1; REGSELB = 1'b1;
    repeat (20) @(negedge CLK);
    check("after_hold_rst", 16'(SOFT_RESET), 16'h0);
`else
    host_write(16'h0200, 8'h81, 1'b0);
    do_read(16'h0200);
    check("cor7_plain", 16'(D_out), 16'h81);
    check("cor7_conf", 16'(CONFIGURED), 16'h1);
    check("cor7_no_sreset", 16'(SOFT_RESET), 16'h0);
    OE = 1'b1; REGSELB = 1'b1;
`endif

    // reset mid-pulse
    host_write(16'h0200, 8'h01, 1'b0);
    @(negedge CLK);
    IRQ_IN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (IREQ) break;
    end
    check("midpulse_started", 16'(IREQ), 16'h1);
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    reset_checks("midpulse");
    IRQ_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0; OE = 1'b1; REGSELB = 1'b1;
    repeat (12) @(negedge CLK);
    check("after_pulse_rst", 16'(IREQ), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
